// File: rtl/ldlt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ldlt_pkg
// Description : Shared types and helpers for the LDL^T triangular solver:
//               default word format, matrix sizing, FSM state encoding,
//               packed-triangle addressing and signed saturation.
// Revision    : 1.0 - initial release
// ============================================================================
package ldlt_pkg;

  localparam int DEF_DATA_LEN = 34;
  localparam int DEF_NODE_NUM = 100;
  localparam int DEF_FRACTION = 16;
  localparam int DEF_DIM      = 6 * DEF_NODE_NUM;
  localparam int DEF_TRI_SIZE = DEF_DIM * (DEF_DIM + 1) / 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADM = 3'd1,
    S_LOADB = 3'd2,
    S_FWD   = 3'd3,
    S_DIAG  = 3'd4,
    S_BWD   = 3'd5,
    S_WRTE  = 3'd6
  } state_t;

  function automatic int dim_of(input int nodes);
    return 6 * nodes;
  endfunction

  function automatic int tri_size(input int dim);
    return dim * (dim + 1) / 2;
  endfunction

  // Column-major packed lower triangle: column j holds rows j..dim-1.
  function automatic int tri_addr(input int i, input int j, input int dim);
    return j * dim - (j * (j - 1)) / 2 + (i - j);
  endfunction

  // Clamp a wide signed value into a w-bit signed range.
  function automatic logic signed [127:0] sat_val(input logic signed [127:0] v, input int w);
    logic signed [127:0] mx;
    logic signed [127:0] mn;
    mx = (128'sd1 <<< (w - 1)) - 128'sd1;
    mn = -(128'sd1 <<< (w - 1));
    if (v > mx)      return mx;
    else if (v < mn) return mn;
    else             return v;
  endfunction

  // True when v does not fit in a w-bit signed word.
  function automatic logic sat_ovf(input logic signed [127:0] v, input int w);
    logic signed [127:0] mx;
    logic signed [127:0] mn;
    mx = (128'sd1 <<< (w - 1)) - 128'sd1;
    mn = -(128'sd1 <<< (w - 1));
    return (v > mx) || (v < mn);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ldlt_tri_ram.sv
`default_nettype none
// ============================================================================
// Module      : ldlt_tri_ram
// Description : Packed lower-triangle store (D on the diagonal, L below).
//               One synchronous write port, one combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module ldlt_tri_ram #(
  parameter int DATA_LEN = 34,
  parameter int DEPTH    = 21,
  parameter int AW       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [DATA_LEN-1:0] i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic [DATA_LEN-1:0] o_rdata
);

  logic [DATA_LEN-1:0] mem_q [DEPTH];

  // Matrix words land here during load; whole store clears on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) mem_q[a] <= '0;
    end else if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/ldlt_tri_solver.sv
`default_nettype none
// ============================================================================
// Module      : ldlt_tri_solver
// Description : Solves A x = b from an LDL^T factor stream: forward
//               substitution, diagonal scaling, back substitution, then
//               streams x out. One MAC or divide per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ldlt_tri_solver
  import ldlt_pkg::*;
#(
  parameter int DATA_LEN = DEF_DATA_LEN,
  parameter int NODE_NUM = DEF_NODE_NUM,
  parameter int FRACTION = DEF_FRACTION
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_valid,
  input  logic [DATA_LEN-1:0] i_data,
  output logic                o_ready,
  output logic                o_valid,
  output logic [DATA_LEN-1:0] o_data,
  output logic                o_last,
  output logic                o_err
);

  localparam int DIM  = dim_of(NODE_NUM);
  localparam int TRI  = tri_size(DIM);
  // DIM is a multiple of 6, never a power of two, so IW bits index DIM entries and also hold DIM
  localparam int IW   = $clog2(DIM + 1);
  localparam int CW   = $clog2(TRI);
  localparam int AW   = DATA_LEN + FRACTION;

  state_t                     state_q, state_d;
  logic [IW-1:0]              row_q, row_d, col_q, col_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic signed [AW-1:0]       acc_q, acc_d;
  logic                       ready_q, ready_d, valid_q, valid_d, last_q, last_d, err_q, err_d;
  logic [DATA_LEN-1:0]        data_q, data_d;
  logic [DATA_LEN-1:0]        vec_q [DIM];
  logic                       vec_we;
  logic [IW-1:0]              vec_waddr;
  logic [DATA_LEN-1:0]        vec_wdata;
  logic                       ram_we;
  logic [CW-1:0]              ram_raddr;
  logic [DATA_LEN-1:0]        ram_rdata;

  logic signed [DATA_LEN-1:0] l_val, v_row, v_col;
  logic [IW-1:0]              col_idx;
  logic signed [2*DATA_LEN-1:0] prod;
  logic signed [AW-1:0]       acc_cur, acc_mac;
  logic signed [AW:0]         num, den, quo;
  logic                       first, commit, d_zero;

  ldlt_tri_ram #(.DATA_LEN(DATA_LEN), .DEPTH(TRI), .AW(CW)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (ram_we),
    .i_waddr (cnt_q),
    .i_wdata (i_data),
    .i_raddr (ram_raddr),
    .o_rdata (ram_rdata)
  );

  // Shared datapath: row/column operand fetch, one MAC step and one divide
  always_comb begin
    ram_raddr = '0;
    first     = 1'b0;
    commit    = 1'b0;
    case (state_q)
      S_FWD: begin
        ram_raddr = CW'(tri_addr(int'(row_q), int'(col_q), DIM));
        first     = (col_q == '0);
        commit    = (col_q == row_q);
      end
      S_DIAG: ram_raddr = CW'(tri_addr(int'(row_q), int'(row_q), DIM));
      S_BWD: begin
        if (col_q < IW'(DIM)) ram_raddr = CW'(tri_addr(int'(col_q), int'(row_q), DIM));
        first  = (col_q == row_q + IW'(1));
        commit = (col_q == IW'(DIM));
      end
      default: ;
    endcase
    col_idx = (col_q < IW'(DIM)) ? col_q : '0;
    l_val   = $signed(ram_rdata);
    v_row   = $signed(vec_q[row_q]);
    v_col   = $signed(vec_q[col_idx]);
    acc_cur = first ? $signed({{FRACTION{v_row[DATA_LEN-1]}}, v_row}) : acc_q;
    prod    = $signed({{DATA_LEN{l_val[DATA_LEN-1]}}, l_val}) *
              $signed({{DATA_LEN{v_col[DATA_LEN-1]}}, v_col});
    acc_mac = acc_cur - AW'(prod >>> FRACTION);
    d_zero  = (l_val == '0);
    num     = $signed({v_row[DATA_LEN-1], v_row, {FRACTION{1'b0}}});
    den     = d_zero ? (AW+1)'(1) : $signed({{(FRACTION+1){l_val[DATA_LEN-1]}}, l_val});
    quo     = num / den;
  end

  // Next-state and next-output logic for the whole job sequence
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;
    data_d    = '0;
    last_d    = 1'b0;
    err_d     = err_q;
    vec_we    = 1'b0;
    vec_waddr = row_q;
    vec_wdata = '0;
    ram_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LOADM;
          ready_d = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_LOADM: begin
        if (i_valid && ready_q) begin
          ram_we = 1'b1;
          if (cnt_q == CW'(TRI - 1)) begin
            cnt_d   = '0;
            state_d = S_LOADB;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_LOADB: begin
        if (i_valid && ready_q) begin
          vec_we    = 1'b1;
          vec_waddr = cnt_q[IW-1:0];
          vec_wdata = i_data;
          if (cnt_q == CW'(DIM - 1)) begin
            cnt_d   = '0;
            ready_d = 1'b0;
            row_d   = '0;
            col_d   = '0;
            state_d = S_FWD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FWD, S_BWD: begin
        if (commit) begin
          vec_we    = 1'b1;
          vec_wdata = DATA_LEN'(sat_val({{(128-AW){acc_cur[AW-1]}}, acc_cur}, DATA_LEN));
          err_d     = err_q | sat_ovf({{(128-AW){acc_cur[AW-1]}}, acc_cur}, DATA_LEN);
          if (state_q == S_FWD) begin
            if (row_q == IW'(DIM - 1)) begin
              row_d   = '0;
              state_d = S_DIAG;
            end else begin
              row_d = row_q + IW'(1);
              col_d = '0;
            end
          end else begin
            if (row_q == '0) begin
              cnt_d   = '0;
              state_d = S_WRTE;
            end else begin
              row_d = row_q - IW'(1);
              col_d = row_q;
            end
          end
        end else begin
          acc_d = acc_mac;
          col_d = col_q + IW'(1);
        end
      end
      S_DIAG: begin
        vec_we    = 1'b1;
        vec_wdata = d_zero ? '0 : DATA_LEN'(sat_val({{(127-AW){quo[AW]}}, quo}, DATA_LEN));
        err_d     = err_q | d_zero | (!d_zero && sat_ovf({{(127-AW){quo[AW]}}, quo}, DATA_LEN));
        if (row_q == IW'(DIM - 1)) begin
          col_d   = IW'(DIM);
          state_d = S_BWD;
        end else begin
          row_d = row_q + IW'(1);
        end
      end
      S_WRTE: begin
        if (cnt_q == CW'(DIM)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          valid_d = 1'b1;
          data_d  = vec_q[cnt_q[IW-1:0]];
          last_d  = (cnt_q == CW'(DIM - 1));
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, vector register file and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int v = 0; v < DIM; v++) vec_q[v] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
      if (vec_we) vec_q[vec_waddr] <= vec_wdata;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ldlt_tri_solver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ldlt_tri_solver
// Description : Self-checking bench for ldlt_tri_solver at NODE_NUM=1 (DIM=6)
//               with directed jobs and randomized jobs against a plain
//               substitution model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ldlt_tri_solver;

  localparam int DL  = 34;
  localparam int FR  = 16;
  localparam int DIM = 6;
  localparam longint ONE = 65536;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_valid = 1'b0;
  logic [DL-1:0] i_data = '0;
  logic          o_ready, o_valid, o_last, o_err;
  logic [DL-1:0] o_data;

  int errors = 0;
  int checks = 0;

  longint lm [DIM][DIM];
  longint dv [DIM];
  longint bv [DIM];
  longint ex [DIM];
  logic   ex_err;
  longint got [DIM];
  logic   got_last [DIM];
  logic   tmo;

  always #5 clk = ~clk;

  ldlt_tri_solver #(.DATA_LEN(DL), .NODE_NUM(1), .FRACTION(FR)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_err   (o_err)
  );

  function automatic longint msat(input longint v);
    longint mx, mn;
    mx = (64'sd1 <<< (DL - 1)) - 1;
    mn = -(64'sd1 <<< (DL - 1));
    if (v > mx) begin ex_err = 1'b1; return mx; end
    if (v < mn) begin ex_err = 1'b1; return mn; end
    return v;
  endfunction

  // Reference: L y = b, z = D^-1 y, L^T x = z with the stated rounding rules
  task automatic model_solve();
    longint acc;
    longint y [DIM];
    ex_err = 1'b0;
    for (int i = 0; i < DIM; i++) begin
      acc = bv[i];
      for (int k = 0; k < i; k++) acc -= (lm[i][k] * y[k]) >>> FR;
      y[i] = msat(acc);
    end
    for (int i = 0; i < DIM; i++) begin
      if (dv[i] == 0) begin y[i] = 0; ex_err = 1'b1; end
      else y[i] = msat((y[i] <<< FR) / dv[i]);
    end
    for (int i = DIM - 1; i >= 0; i--) begin
      acc = y[i];
      for (int k = i + 1; k < DIM; k++) acc -= (lm[k][i] * ex[k]) >>> FR;
      ex[i] = msat(acc);
    end
  endtask

  task automatic set_identity(input longint d);
    for (int i = 0; i < DIM; i++) begin
      dv[i] = d;
      bv[i] = 0;
      for (int j = 0; j < DIM; j++) lm[i][j] = 0;
    end
  endtask

  task automatic load_job(input bit gap);
    longint words [$];
    int n, guard;
    bit ph, acc;
    words = {};
    for (int j = 0; j < DIM; j++)
      for (int i = j; i < DIM; i++) words.push_back(i == j ? dv[j] : lm[i][j]);
    for (int i = 0; i < DIM; i++) words.push_back(bv[i]);
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    n = 0; ph = 1'b0; guard = 0;
    while (n < words.size() && guard < 1000) begin
      if (gap && ph) i_valid = 1'b0;
      else begin i_valid = 1'b1; i_data = DL'(words[n]); end
      ph  = ~ph;
      acc = i_valid && o_ready;
      @(negedge clk);
      if (acc) n++;
      guard++;
    end
    i_valid = 1'b0;
    if (n < words.size()) begin
      errors++; checks++;
      $display("FAIL load_timeout accepted=%0d required=%0d", n, words.size());
    end
  endtask

  task automatic collect_out();
    int cnt, guard;
    cnt = 0; guard = 0; tmo = 1'b0;
    while (cnt < DIM && guard < 2000) begin
      @(negedge clk); guard++;
      if (o_valid) begin
        got[cnt] = longint'($signed(o_data));
        got_last[cnt] = o_last;
        cnt++;
      end
    end
    if (cnt < DIM) begin
      tmo = 1'b1; errors++; checks++;
      $display("FAIL collect_timeout got=%0d required=%0d", cnt, DIM);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_ready, o_valid, o_last, o_err, o_data} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h required=0", {o_ready, o_valid, o_last, o_err, o_data});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_ready, o_valid, o_err} !== 3'b000) begin
      errors++; $display("FAIL idle_outputs got=%b required=000", {o_ready, o_valid, o_err});
    end
  endtask

  task automatic test_identity();
    set_identity(ONE);
    for (int i = 0; i < DIM; i++) bv[i] = (i + 1) * ONE;
    load_job(1'b0);
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL ready_drop got=%b required=0", o_ready); end
    collect_out();
    for (int i = 0; i < DIM; i++) begin
      checks++;
      if (got[i] !== (i + 1) * ONE) begin errors++; $display("FAIL ident_x[%0d] got=%0d required=%0d", i, got[i], (i + 1) * ONE); end
      checks++;
      if (got_last[i] !== (i == DIM - 1)) begin errors++; $display("FAIL ident_last[%0d] got=%b", i, got_last[i]); end
    end
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL ident_err got=%b required=0", o_err); end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL ident_valid_drop got=%b required=0", o_valid); end
  endtask

  task automatic test_diag2();
    set_identity(2 * ONE);
    for (int i = 0; i < DIM; i++) bv[i] = ONE;
    load_job(1'b0);
    collect_out();
    for (int i = 0; i < DIM; i++) begin
      checks++;
      if (got[i] !== 32768) begin errors++; $display("FAIL diag2_x[%0d] got=%0d required=32768", i, got[i]); end
    end
  endtask

  task automatic test_lower(input bit gap);
    longint exp3 [DIM];
    exp3 = '{81920, -32768, 0, 0, 0, 0};
    set_identity(ONE);
    lm[1][0] = 32768;
    bv[0] = ONE;
    load_job(gap);
    collect_out();
    for (int i = 0; i < DIM; i++) begin
      checks++;
      if (got[i] !== exp3[i]) begin errors++; $display("FAIL lower_x[%0d] gap=%0d got=%0d required=%0d", i, gap, got[i], exp3[i]); end
    end
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL lower_err got=%b required=0", o_err); end
  endtask

  task automatic test_dzero();
    set_identity(ONE);
    dv[2] = 0;
    for (int i = 0; i < DIM; i++) bv[i] = (i + 1) * ONE;
    load_job(1'b0);
    collect_out();
    for (int i = 0; i < DIM; i++) begin
      checks++;
      if (got[i] !== ((i == 2) ? 0 : (i + 1) * ONE)) begin
        errors++; $display("FAIL dzero_x[%0d] got=%0d required=%0d", i, got[i], (i == 2) ? 0 : (i + 1) * ONE);
      end
    end
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL dzero_err got=%b required=1", o_err); end
    dv[2] = ONE;
    load_job(1'b0);
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b required=0", o_err); end
    collect_out();
    checks++;
    if (got[2] !== 3 * ONE || o_err !== 1'b0) begin
      errors++; $display("FAIL dzero_next got=%0d err=%b required=%0d err=0", got[2], o_err, 3 * ONE);
    end
  endtask

  task automatic test_random(input int jobs);
    for (int t = 0; t < jobs; t++) begin
      for (int i = 0; i < DIM; i++) begin
        dv[i] = longint'($urandom_range(262144, 32768));
        bv[i] = longint'($urandom_range(2097152, 0)) - 1048576;
        for (int j = 0; j < DIM; j++) lm[i][j] = (i > j) ? longint'($urandom_range(65536, 0)) - 32768 : 0;
      end
      model_solve();
      load_job(t[0]);
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      collect_out();
      for (int i = 0; i < DIM; i++) begin
        checks++;
        if (got[i] !== ex[i]) begin errors++; $display("FAIL rand%0d_x[%0d] got=%0d required=%0d", t, i, got[i], ex[i]); end
      end
      checks++;
      if (o_err !== ex_err) begin errors++; $display("FAIL rand%0d_err got=%b required=%b", t, o_err, ex_err); end
    end
  endtask

  task automatic test_saturate();
    set_identity(ONE);
    dv[0] = 1;
    bv[0] = (64'sd1 <<< (DL - 1)) - 1;
    bv[3] = -5 * ONE;
    lm[3][0] = 100;
    model_solve();
    load_job(1'b0);
    collect_out();
    for (int i = 0; i < DIM; i++) begin
      checks++;
      if (got[i] !== ex[i]) begin errors++; $display("FAIL sat_x[%0d] got=%0d required=%0d", i, got[i], ex[i]); end
    end
    checks++;
    if (o_err !== ex_err) begin errors++; $display("FAIL sat_err got=%b required=%b", o_err, ex_err); end
  endtask

  task automatic test_reset_abort();
    set_identity(ONE);
    for (int i = 0; i < DIM; i++) bv[i] = (i + 1) * ONE;
    lm[4][1] = 12345;
    load_job(1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_ready, o_valid, o_last, o_err, o_data} !== '0) begin
      errors++; $display("FAIL abort_outputs got=%h required=0", {o_ready, o_valid, o_last, o_err, o_data});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    lm[4][1] = 0;
    load_job(1'b0);
    collect_out();
    for (int i = 0; i < DIM; i++) begin
      checks++;
      if (got[i] !== (i + 1) * ONE) begin errors++; $display("FAIL abort_x[%0d] got=%0d required=%0d", i, got[i], (i + 1) * ONE); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_diag2();
    test_lower(1'b0);
    test_dzero();
    test_lower(1'b1);
    test_random(4);
    test_saturate();
    test_reset_abort();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
